// File: rtl/npuarc_to_monitor_mc.sv
// Multi-channel timeout monitor: per-channel arm/count/expire FSMs, sticky flags and first-expiry capture.
// Define NPUARC_TO_MON_PRESCALE_EN to build the shared tick prescaler; otherwise every enabled cycle is a tick.
module npuarc_to_monitor_mc #(
  parameter int TO_EN  = 1,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int PRE_W  = 4,
  parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clk_en_i,
  input  logic              mon_en_i,
  input  logic [NUM_CH-1:0] to_start_i,
  input  logic [NUM_CH-1:0] to_end_i,
  input  logic [CNT_W-1:0]  to_limit_i,
  input  logic [PRE_W-1:0]  pre_div_i,
  output logic [NUM_CH-1:0] to_flag_o,
  output logic              to_any_o,
  output logic              to_first_vld_o,
  output logic [ID_W-1:0]   to_first_id_o
);

  // state   | meaning
  // ST_IDLE | channel disarmed, counter 0
  // ST_RUN  | armed, counting ticks toward to_limit
  // ST_EXP  | timed out, flag set until an end edge
  if (TO_EN != 0) begin : g_mon
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_EXP} st_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   INC_ONE = (CNT_W + 1)'(1);

    st_e               st_q  [NUM_CH];
    st_e               st_d  [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] start_r_q, end_r_q;
    logic [NUM_CH-1:0] start_rise, end_rise;
    logic [NUM_CH-1:0] flag_q, flag_d, flag_rise;
    logic              first_vld_q, first_vld_d;
    logic [ID_W-1:0]   first_id_q, first_id_d;
    logic              en, clr, tick;

    assign en         = clk_en_i & mon_en_i;
    assign clr        = clk_en_i & ~mon_en_i;
    assign start_rise = to_start_i & ~start_r_q;
    assign end_rise   = to_end_i & ~end_r_q;

`ifdef NPUARC_TO_MON_PRESCALE_EN
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

    // Free-running; a pre_div below pre_cnt simply wraps through the maximum.
    assign tick = en & (pre_cnt_q == pre_div_i);

    always_comb begin
      pre_cnt_d = pre_cnt_q;
      if (en) pre_cnt_d = (pre_cnt_q == pre_div_i) ? '0 : pre_cnt_q + PRE_ONE;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) pre_cnt_q <= '0;
      else          pre_cnt_q <= pre_cnt_d;
    end
`else
    logic unused_pre;
    assign unused_pre = ^pre_div_i;
    assign tick       = en;
`endif

    always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_d[i]  = st_q[i];
        cnt_d[i] = cnt_q[i];
        if (clr) begin
          st_d[i]  = ST_IDLE;
          cnt_d[i] = '0;
        end else if (en) begin
          unique case (st_q[i])
            ST_IDLE: begin
              if (start_rise[i] && !end_rise[i]) begin
                st_d[i]  = ST_RUN;
                cnt_d[i] = '0;
              end
            end
            ST_RUN: begin
              if (end_rise[i]) begin
                st_d[i]  = ST_IDLE;
                cnt_d[i] = '0;
              end else if (start_rise[i]) begin
                cnt_d[i] = '0;
              end else if (tick) begin
                // Compare one bit wider so cnt+1 cannot wrap past a full-scale limit.
                if ((to_limit_i != '0) &&
                    (({1'b0, cnt_q[i]} + INC_ONE) >= {1'b0, to_limit_i})) begin
                  st_d[i] = ST_EXP;
                end else if (cnt_q[i] != '1) begin
                  cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
              end
            end
            ST_EXP: begin
              if (end_rise[i]) begin
                st_d[i]  = ST_IDLE;
                cnt_d[i] = '0;
              end
            end
            default: begin
              st_d[i]  = ST_IDLE;
              cnt_d[i] = '0;
            end
          endcase
        end
      end
    end

    always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
        flag_q[i] = (st_q[i] == ST_EXP);
        flag_d[i] = (st_d[i] == ST_EXP);
      end
    end

    assign flag_rise = flag_d & ~flag_q;

    // A rise in the cycle where to_any is already low starts a fresh capture rather than being lost.
    always_comb begin
      first_vld_d = first_vld_q;
      first_id_d  = first_id_q;
      if (clr) begin
        first_vld_d = 1'b0;
        first_id_d  = '0;
      end else if (en) begin
        if ((!first_vld_q || !to_any_o) && (|flag_rise)) begin
          first_vld_d = 1'b1;
          for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (flag_rise[i]) first_id_d = ID_W'(i);
          end
        end else if (!to_any_o) begin
          first_vld_d = 1'b0;
          first_id_d  = '0;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        start_r_q   <= '0;
        end_r_q     <= '0;
        first_vld_q <= 1'b0;
        first_id_q  <= '0;
        for (int i = 0; i < NUM_CH; i++) begin
          st_q[i]  <= ST_IDLE;
          cnt_q[i] <= '0;
        end
      end else begin
        if (clk_en_i) begin
          start_r_q <= to_start_i;
          end_r_q   <= to_end_i;
        end
        first_vld_q <= first_vld_d;
        first_id_q  <= first_id_d;
        for (int i = 0; i < NUM_CH; i++) begin
          st_q[i]  <= st_d[i];
          cnt_q[i] <= cnt_d[i];
        end
      end
    end

    assign to_flag_o      = flag_q;
    assign to_any_o       = |flag_q;
    assign to_first_vld_o = first_vld_q;
    assign to_first_id_o  = first_id_q;
  end else begin : g_off
    logic unused_in;
    assign unused_in = ^{clk_i, rst_n_i, clk_en_i, mon_en_i, to_start_i, to_end_i,
                         to_limit_i, pre_div_i};
    assign to_flag_o      = '0;
    assign to_any_o       = 1'b0;
    assign to_first_vld_o = 1'b0;
    assign to_first_id_o  = '0;
  end

endmodule

// File: tb/tb_npuarc_to_monitor_mc.sv
// Self-checking bench for npuarc_to_monitor_mc: per-cycle compare against a behavioural model plus
// hand-computed checkpoints. Prescaler timing is exercised when NPUARC_TO_MON_PRESCALE_EN is defined.
module tb_npuarc_to_monitor_mc;

  logic       clk = 1'b0;
  logic       rst_n, clk_en, mon_en;
  logic [3:0] to_start, to_end;
  logic [7:0] to_limit;
  logic [3:0] pre_div;
  logic [3:0] to_flag;
  logic       to_any, to_first_vld;
  logic [1:0] to_first_id;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  npuarc_to_monitor_mc #(.TO_EN(1), .NUM_CH(4), .CNT_W(8), .PRE_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .mon_en_i(mon_en),
    .to_start_i(to_start), .to_end_i(to_end), .to_limit_i(to_limit), .pre_div_i(pre_div),
    .to_flag_o(to_flag), .to_any_o(to_any), .to_first_vld_o(to_first_vld),
    .to_first_id_o(to_first_id)
  );

  // Model: mode 0 idle, 1 running, 2 expired; el = ticks seen since arming (unbounded).
  int         m_mode [4];
  int         m_el   [4];
  logic [3:0] m_sp, m_ep;
  logic       m_vld;
  int         m_id;
  int         m_pre;
  logic [3:0] m_sr, m_er, m_oldf, m_newf, m_rise;
  logic       m_tk;

  function automatic logic [3:0] mflags();
    logic [3:0] f;
    for (int i = 0; i < 4; i++) f[i] = (m_mode[i] == 2);
    return f;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin m_mode[i] = 0; m_el[i] = 0; end
      m_sp = '0; m_ep = '0; m_vld = 1'b0; m_id = 0; m_pre = 0;
    end else if (clk_en) begin
      m_sr = to_start & ~m_sp;
      m_er = to_end & ~m_ep;
      m_sp = to_start;
      m_ep = to_end;
      if (!mon_en) begin
        for (int i = 0; i < 4; i++) begin m_mode[i] = 0; m_el[i] = 0; end
        m_vld = 1'b0; m_id = 0;
      end else begin
`ifdef NPUARC_TO_MON_PRESCALE_EN
        m_tk  = (m_pre == int'(pre_div));
        m_pre = m_tk ? 0 : ((m_pre + 1) % 16);
`else
        m_tk = 1'b1;
`endif
        m_oldf = mflags();
        for (int i = 0; i < 4; i++) begin
          if (m_mode[i] == 0) begin
            if (m_sr[i] && !m_er[i]) begin m_mode[i] = 1; m_el[i] = 0; end
          end else if (m_mode[i] == 1) begin
            if (m_er[i]) begin m_mode[i] = 0; m_el[i] = 0; end
            else if (m_sr[i]) m_el[i] = 0;
            else if (m_tk) begin
              if (to_limit != 0 && ((m_el[i] > 255 ? 255 : m_el[i]) + 1) >= int'(to_limit))
                m_mode[i] = 2;
              else
                m_el[i] = m_el[i] + 1;
            end
          end else if (m_er[i]) begin
            m_mode[i] = 0; m_el[i] = 0;
          end
        end
        m_newf = mflags();
        m_rise = m_newf & ~m_oldf;
        if (m_rise != 0 && (!m_vld || m_oldf == 0)) begin
          m_vld = 1'b1;
          m_id  = 0;
          while (!m_rise[m_id]) m_id++;
        end else if (m_oldf == 0) begin
          m_vld = 1'b0; m_id = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_flag", int'(to_flag), int'(mflags()));
      chk("model_any", int'(to_any), int'(|mflags()));
      chk("model_vld", int'(to_first_vld), int'(m_vld));
      chk("model_id", int'(to_first_id), m_id);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_all();
    to_start = '0;
    to_end   = '1;
    step(1);
    to_end = '0;
    step(2);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; clk_en = 1'b1; mon_en = 1'b1;
    to_start = '0; to_end = '0; to_limit = 8'd5; pre_div = '0;
    step(3);
    chk_on = 1'b1;
    chk("reset_flag", int'(to_flag), 0);
    chk("reset_vld", int'(to_first_vld), 0);
    rst_n = 1'b1;
    step(2);

    // Basic expiry on ch0 with L=5
    to_start[0] = 1'b1;
    step(5);
    chk("basic_before", int'(to_flag), 0);
    step(1);
    chk("basic_flag", int'(to_flag), 4'b0001);
    chk("basic_any", int'(to_any), 1);
    chk("basic_id", int'(to_first_id), 0);
    to_end[0] = 1'b1;
    step(1);
    chk("basic_clear", int'(to_flag), 0);
    chk("basic_vld_lag", int'(to_first_vld), 1);
    step(1);
    chk("basic_vld_off", int'(to_first_vld), 0);
    clear_all();

    // Early end on ch1, then re-arm shows counter restarted from 0
    to_start[1] = 1'b1;
    step(3);
    to_end[1] = 1'b1;
    step(10);
    chk("early_noflag", int'(to_flag), 0);
    to_start[1] = 1'b0; to_end[1] = 1'b0;
    step(1);
    to_start[1] = 1'b1;
    step(5);
    chk("rearm_before", int'(to_flag), 0);
    step(1);
    chk("rearm_flag", int'(to_flag), 4'b0010);
    clear_all();

    // Simultaneous expiry of ch1 and ch3
    to_start = 4'b1010;
    step(6);
    chk("simul_flags", int'(to_flag), 4'b1010);
    chk("simul_id", int'(to_first_id), 1);
    to_end[1] = 1'b1;
    step(4);
    chk("simul_hold_flag", int'(to_flag), 4'b1000);
    chk("simul_hold_id", int'(to_first_id), 1);
    to_end[3] = 1'b1;
    step(2);
    chk("simul_all_clear", int'(to_first_vld), 0);
    clear_all();

    // L=0 never expires; counter saturates so raising L to 255 expires on the next tick
    to_limit = 8'd0;
    to_start[2] = 1'b1;
    step(301);
    chk("l0_noflag", int'(to_flag), 0);
    to_limit = 8'd255;
    step(1);
    chk("sat_expire", int'(to_flag), 4'b0100);
    clear_all();
    to_limit = 8'd5;
    to_start[0] = 1'b1; to_end[0] = 1'b1;
    step(10);
    chk("start_end_same", int'(to_flag), 0);
    clear_all();

    // Clock-enable freeze mid-RUN
    to_limit = 8'd20;
    to_start[0] = 1'b1;
    step(3);
    clk_en = 1'b0;
    step(20);
    clk_en = 1'b1;
    step(17);
    chk("gate_before", int'(to_flag), 0);
    step(1);
    chk("gate_flag", int'(to_flag), 4'b0001);
    mon_en = 1'b0;
    step(1);
    chk("monen_flag", int'(to_flag), 0);
    chk("monen_vld", int'(to_first_vld), 0);
    mon_en = 1'b1;
    step(25);
    chk("monen_no_false_edge", int'(to_flag), 0);
    clear_all();

    // Reset while expired
    to_limit = 8'd3;
    to_start[3] = 1'b1;
    step(4);
    chk("rst_pre_flag", int'(to_flag), 4'b1000);
    rst_n = 1'b0;
    step(1);
    chk("rst_flag", int'(to_flag), 0);
    chk("rst_any", int'(to_any), 0);
    chk("rst_vld", int'(to_first_vld), 0);
    rst_n = 1'b1;
    clear_all();

`ifdef NPUARC_TO_MON_PRESCALE_EN
    pre_div = 4'd3;
    to_limit = 8'd4;
    to_start[0] = 1'b1;
    n = 0;
    while (!to_flag[0] && n < 40) begin
      step(1);
      n++;
    end
    chk("pre_lat_min", int'(n >= 13), 1);
    chk("pre_lat_max", int'(n <= 16), 1);
    clear_all();
    pre_div = 4'd0;
`endif
    n = 0;

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
